// File: rtl/block_spi_master.sv
// ---- block_spi_master : SPI mode-0 initiator, one {address,data} 16-bit frame per start (rev 1.0)
// ---- Define SPI_MASTER_READBACK_EN to capture the 16 bits returned on MISO during the frame.
`default_nettype none

module block_spi_master #(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       start,
  input  logic [7:0] address_in,
  input  logic [7:0] data_in,
  output logic       busy,
  output logic       done,
  output logic [7:0] rx_address,
  output logic [7:0] rx_data,
  output logic       SPI_SCK,
  output logic       SPI_CS,
  output logic       SPI_MOSI,
  input  logic       SPI_MISO
);

  localparam int               CNT_W      = $clog2(CLK_DIV + 1);
  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(CLK_DIV - 1);
  localparam logic [4:0]       LAST_BIT   = 5'd16;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SETUP = 2'd1,
    S_SHIFT = 2'd2,
    S_GAP   = 2'd3
  } state_t;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [4:0]       bit_q;
  logic [15:0]      tx_q;
  logic             sck_q;
  logic             cs_q;
  logic             mosi_q;
  logic             busy_q;
  logic             done_q;

  logic             phase_end;
  logic             sample_en;
  logic             finish_en;
  logic [CNT_W-1:0] cnt_dec;

  assign phase_end = (cnt_q == '0);
  assign cnt_dec   = cnt_q - CNT_W'(1);
  // sample_en marks the edge on which SCK is driven 0->1
  assign sample_en = phase_end &&
                     ((state_q == S_SETUP) ||
                      ((state_q == S_SHIFT) && !sck_q && (bit_q != LAST_BIT)));
  assign finish_en = phase_end && (state_q == S_GAP);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      tx_q    <= '0;
      sck_q   <= 1'b0;
      cs_q    <= 1'b1;
      mosi_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            tx_q    <= {address_in, data_in};
            mosi_q  <= address_in[7];
            cs_q    <= 1'b0;
            busy_q  <= 1'b1;
            cnt_q   <= CNT_RELOAD;
            bit_q   <= '0;
            state_q <= S_SETUP;
          end
        end
        S_SETUP: begin
          if (phase_end) begin
            sck_q   <= 1'b1;
            bit_q   <= 5'd1;
            cnt_q   <= CNT_RELOAD;
            state_q <= S_SHIFT;
          end else begin
            cnt_q <= cnt_dec;
          end
        end
        S_SHIFT: begin
          if (phase_end) begin
            cnt_q <= CNT_RELOAD;
            if (sck_q) begin
              sck_q <= 1'b0;
              if (bit_q != LAST_BIT) begin
                tx_q   <= {tx_q[14:0], 1'b0};
                mosi_q <= tx_q[14];
              end
            end else if (bit_q == LAST_BIT) begin
              cs_q    <= 1'b1;
              mosi_q  <= 1'b0;
              state_q <= S_GAP;
            end else begin
              sck_q <= 1'b1;
              bit_q <= bit_q + 5'd1;
            end
          end else begin
            cnt_q <= cnt_dec;
          end
        end
        S_GAP: begin
          if (phase_end) begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            cnt_q <= cnt_dec;
          end
        end
        default: begin
          state_q <= S_IDLE;
          cs_q    <= 1'b1;
          sck_q   <= 1'b0;
          mosi_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

`ifdef SPI_MASTER_READBACK_EN
  logic [15:0] rx_q;
  logic [7:0]  rx_address_q;
  logic [7:0]  rx_data_q;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      rx_q         <= '0;
      rx_address_q <= '0;
      rx_data_q    <= '0;
    end else begin
      if (sample_en) begin
        rx_q <= {rx_q[14:0], SPI_MISO};
      end
      if (finish_en) begin
        rx_address_q <= rx_q[15:8];
        rx_data_q    <= rx_q[7:0];
      end
    end
  end

  assign rx_address = rx_address_q;
  assign rx_data    = rx_data_q;
`else
  logic miso_unused;
  logic sample_unused;
  logic finish_unused;

  assign miso_unused   = SPI_MISO;
  assign sample_unused = sample_en;
  assign finish_unused = finish_en;
  assign rx_address    = 8'h00;
  assign rx_data       = 8'h00;
`endif

  assign busy     = busy_q;
  assign done     = done_q;
  assign SPI_SCK  = sck_q;
  assign SPI_CS   = cs_q;
  assign SPI_MOSI = mosi_q;

endmodule

`default_nettype wire
